// File: rtl/te_radio_pkg.sv
// te_radio_pkg: shared state encoding, default timing parameters and helpers
// for the radio enable sequencer.
package te_radio_pkg;
   typedef enum logic [2:0] {IDLE, WARMUP, EN, RX, DRAIN} te_radio_st_e;
   localparam int SYNC_STAGES_DEF = 2;
   localparam int FILT_CYC_DEF    = 3;
   localparam int WARMUP_CYC_DEF  = 8;
   localparam int DRAIN_CYC_DEF   = 4;
   function automatic int max_i(input int a, input int b);
      return (a > b) ? a : b;
   endfunction
endpackage

// File: rtl/te_bit_sync_filt.sv
// te_bit_sync_filt: brings one async level onto ck and only follows it after
// it has differed from the filtered value for FILT_CYC consecutive cycles.
module te_bit_sync_filt
   import te_radio_pkg::*;
#(
   parameter int SYNC_STAGES = SYNC_STAGES_DEF,
   parameter int FILT_CYC    = FILT_CYC_DEF
) (
   input  logic ck,
   input  logic arst,
   input  logic d,
   output logic q
);
   localparam int CW = $clog2(FILT_CYC + 1);
   logic [SYNC_STAGES-1:0] sync_q;
   logic [CW-1:0] cnt_q, cnt_d;
   logic filt_q, filt_d;
   logic s;
   assign s = sync_q[SYNC_STAGES-1];
   always_comb begin
      cnt_d  = '0;
      filt_d = filt_q;
      if (s != filt_q) begin
         if (cnt_q == CW'(FILT_CYC - 1)) filt_d = s;
         else cnt_d = cnt_q + 1'b1;
      end
   end
   always_ff @(posedge ck or posedge arst) begin
      if (arst) begin
         sync_q <= '0;
         cnt_q  <= '0;
         filt_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], d};
         cnt_q  <= cnt_d;
         filt_q <= filt_d;
      end
   end
   assign q = filt_q;
endmodule

// File: rtl/te_radio_en_sync.sv
// te_radio_en_sync: synchronises and filters radio enable / rx requests and
// sequences them (warm-up before rx, drain after rx) for the S2->S3 stage.
module te_radio_en_sync
   import te_radio_pkg::*;
#(
   parameter int SYNC_STAGES = SYNC_STAGES_DEF,
   parameter int FILT_CYC    = FILT_CYC_DEF,
   parameter int WARMUP_CYC  = WARMUP_CYC_DEF,
   parameter int DRAIN_CYC   = DRAIN_CYC_DEF
) (
   input  logic ck,
   input  logic arst,
   input  logic isolateM1M2,
   input  logic radio_enable_req,
   input  logic radio_rx_en_req,
   output logic radio_enable_synced,
   output logic radio_rx_en_synced,
   output logic rx_req_err,
   output logic fsm_busy
);
   localparam int TW = $clog2(max_i(WARMUP_CYC, DRAIN_CYC) + 1);
   te_radio_st_e st_q, st_d;
   logic [TW-1:0] tmr_q, tmr_d;
   logic en_f, rx_f, rx_prev_q, en_q, rx_q, err_q, busy_q, err_d;
   te_bit_sync_filt #(.SYNC_STAGES(SYNC_STAGES), .FILT_CYC(FILT_CYC)) u_en (
      .ck(ck), .arst(arst), .d(radio_enable_req), .q(en_f));
   te_bit_sync_filt #(.SYNC_STAGES(SYNC_STAGES), .FILT_CYC(FILT_CYC)) u_rx (
      .ck(ck), .arst(arst), .d(radio_rx_en_req), .q(rx_f));
   always_comb begin
      st_d  = st_q;
      tmr_d = tmr_q;
      if (isolateM1M2) begin
         st_d  = IDLE;
         tmr_d = '0;
      end else begin
         case (st_q)
            IDLE:    if (en_f) begin st_d = WARMUP; tmr_d = TW'(WARMUP_CYC - 1); end
            WARMUP:  if (!en_f) st_d = IDLE;
                     else if (tmr_q == '0) st_d = EN;
                     else tmr_d = tmr_q - 1'b1;
            EN:      if (!en_f) st_d = IDLE;
                     else if (rx_f) st_d = RX;
            RX:      if (!en_f) begin st_d = DRAIN; tmr_d = TW'(DRAIN_CYC - 1); end
                     else if (!rx_f) st_d = EN;
            DRAIN:   if (tmr_q == '0) st_d = IDLE;
                     else tmr_d = tmr_q - 1'b1;
            default: st_d = IDLE;
         endcase
      end
   end
   // rx rising while the radio is not ready is flagged, never queued
   assign err_d = rx_f & ~rx_prev_q & ~isolateM1M2 &
                  (st_q == IDLE || st_q == WARMUP || st_q == DRAIN);
   always_ff @(posedge ck or posedge arst) begin
      if (arst) begin
         st_q      <= IDLE;
         tmr_q     <= '0;
         rx_prev_q <= 1'b0;
         en_q      <= 1'b0;
         rx_q      <= 1'b0;
         err_q     <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         st_q      <= st_d;
         tmr_q     <= tmr_d;
         rx_prev_q <= rx_f;
         en_q      <= st_d != IDLE;
         rx_q      <= st_d == RX;
         err_q     <= err_d;
         busy_q    <= st_d == WARMUP || st_d == DRAIN;
      end
   end
   assign radio_enable_synced = en_q & ~isolateM1M2;
   assign radio_rx_en_synced  = rx_q & ~isolateM1M2;
   assign rx_req_err          = err_q & ~isolateM1M2;
   assign fsm_busy            = busy_q & ~isolateM1M2;
endmodule

// File: tb/tb_te_radio_en_sync.sv
// tb_te_radio_en_sync: directed sequence over filtering, warm-up, drain,
// isolation and async reset; outputs checked as {enable, rx_en, err, busy}.
module tb_te_radio_en_sync;
   logic ck = 1'b0, arst = 1'b1, iso = 1'b0, en_req = 1'b0, rx_req = 1'b0;
   logic en, rx, err, busy;
   int checks = 0, errors = 0, err_seen = 0;
   always #5 ck = ~ck;
   te_radio_en_sync dut (
      .ck(ck), .arst(arst), .isolateM1M2(iso),
      .radio_enable_req(en_req), .radio_rx_en_req(rx_req),
      .radio_enable_synced(en), .radio_rx_en_synced(rx),
      .rx_req_err(err), .fsm_busy(busy));
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic o(input string tag, input logic [3:0] exp);
      chk(tag, {28'b0, en, rx, err, busy}, {28'b0, exp});
   endtask
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge ck);
         #2;
         if (err) err_seen++;
         chk("inv_rx_implies_en", {31'b0, rx & ~en}, 32'd0);
      end
   endtask
   initial begin
      tick(3); o("reset", 4'b0000);
      arst = 1'b0; tick(2);
      en_req = 1'b1; tick(2); en_req = 1'b0; tick(8); o("idle_glitch", 4'b0000);
      en_req = 1'b1;
      tick(5); o("t1_e5", 4'b0000);
      tick(1); o("t1_e6", 4'b1001);
      tick(7); o("t1_e13", 4'b1001);
      tick(1); o("t1_e14_en", 4'b1000);
      en_req = 1'b0; tick(2); en_req = 1'b1; tick(8); o("t3_en_glitch", 4'b1000);
      rx_req = 1'b1; tick(2); rx_req = 1'b0; tick(8); o("t3_rx_glitch", 4'b1000);
      chk("t3_no_err", err_seen, 32'd0);
      en_req = 1'b0;
      tick(5); o("off_e5", 4'b1000);
      tick(1); o("off_e6", 4'b0000);
      tick(4);
      en_req = 1'b1; rx_req = 1'b1;
      tick(5); o("t2_e5", 4'b0000);
      tick(1); o("t2_e6", 4'b1011);
      tick(1); o("t2_e7", 4'b1001);
      tick(7); o("t2_e14", 4'b1000);
      tick(1); o("t2_e15", 4'b1100);
      chk("t2_err_count", err_seen, 32'd1);
      iso = 1'b1; #1; o("t5_clamp", 4'b0000);
      tick(1); o("t5_iso", 4'b0000);
      tick(2); iso = 1'b0; #1; o("t5_release", 4'b0000);
      tick(1); o("t5_rewarm", 4'b1001);
      tick(7); o("t5_warm_end", 4'b1001);
      tick(1); o("t5_en", 4'b1000);
      tick(1); o("t5_rx", 4'b1100);
      en_req = 1'b0; rx_req = 1'b0;
      tick(5); o("t4_e5", 4'b1100);
      tick(1); o("t4_drain", 4'b1001);
      tick(3); o("t4_drain_end", 4'b1001);
      tick(1); o("t4_idle", 4'b0000);
      en_req = 1'b1;
      tick(8); o("t6a_warmup", 4'b1001);
      #1 arst = 1'b1; #1 o("t6a_arst", 4'b0000);
      tick(1); arst = 1'b0;
      tick(5); o("t6a_e5", 4'b0000);
      tick(1); o("t6a_e6", 4'b1001);
      tick(8); o("t6a_en", 4'b1000);
      rx_req = 1'b1;
      tick(6); o("t6b_rx", 4'b1100);
      en_req = 1'b0;
      tick(6); o("t6b_drain", 4'b1001);
      tick(1);
      #1 arst = 1'b1; en_req = 1'b1; rx_req = 1'b0;
      #1 o("t6b_arst", 4'b0000);
      tick(1); arst = 1'b0;
      tick(5); o("t6b_e5", 4'b0000);
      tick(1); o("t6b_e6", 4'b1001);
      chk("final_err_count", err_seen, 32'd1);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
